// File: rtl/boot_ctrl_pkg.sv
// Shared types and constants for the boot/run controller: FSM state
// encoding plus the instruction field layout and opcodes of the core it boots.
package boot_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RST  = 3'd2,
        ST_HALT = 3'd3,
        ST_RUN  = 3'd4,
        ST_STEP = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    // Instruction field positions (16-bit instruction, upper byte at even address)
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int RT_MSB  = 5;
    localparam int RT_LSB  = 3;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_LI  = 4'b1111;

endpackage

// File: rtl/boot_ctrl_if.sv
// Program byte stream from the host into the boot controller.
// Handshake: a byte (s_data, s_last) transfers on every rising clk edge where
// s_valid and s_ready are both 1; the master holds s_data/s_last stable while
// s_valid is 1, and s_ready never depends on s_valid.
interface boot_ctrl_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/rst_stretch.sv
// Down-counter that times the CPU reset stretch after a program load.
// Reloaded with RST_CYCLES when the controller enters RST; done is raised in
// the cycle where the count reaches zero, so RST lasts exactly RST_CYCLES cycles.
module rst_stretch #(
    parameter int RST_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic en,
    output logic done
);
    localparam int CW = $clog2(RST_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reload on entry to RST, count down while in RST
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CW'(RST_CYCLES);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign done = en && !start && (cnt_d == '0);

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/boot_ctrl.sv
// Boot and run controller: streams a program into instruction memory while
// holding the CPU in reset, stretches reset, then sequences the CPU clock
// enable (run / single step / halt).
// Optional feature macro: BOOT_CTRL_CYCLE_CNT_EN enables the saturating
// 16-bit enabled-cycle counter; without it cycle_count is tied to 0.
module boot_ctrl
    import boot_ctrl_pkg::*;
#(
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_W     = 8,
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              halt_req,
    boot_ctrl_if.slave        prog,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_reset,
    output logic              cpu_clk_en,
    output logic              loaded,
    output logic              err,
    output logic [15:0]       cycle_count,
    output state_t            dbg_state
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              loaded_q;
    logic              loaded_d;
    logic              s_ready;
    logic              hs;
    logic              at_end;
    logic              rst_start;
    logic              rst_done;

    assign prog.s_ready = s_ready;
    assign hs           = prog.s_valid & s_ready;
    assign at_end       = (ptr_q == ADDR_W'(MEM_DEPTH - 1));
    assign rst_start    = (state_d == ST_RST) && (state_q != ST_RST);
    assign dbg_state    = state_q;
    assign loaded       = loaded_q;

    rst_stretch #(
        .RST_CYCLES (RST_CYCLES)
    ) u_rst_stretch (
        .clk   (clk),
        .reset (reset),
        .start (rst_start),
        .en    (state_q == ST_RST),
        .done  (rst_done)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: load_req wins everywhere, then halt > step > run where legal
    always_comb begin
        state_d = state_q;
        if (load_req) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD: begin
                    if (hs) begin
                        if (prog.s_last) begin
                            state_d = ST_RST;
                        end else if (at_end) begin
                            state_d = ST_ERR;
                        end
                    end
                end
                ST_RST: begin
                    if (rst_done) begin
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (step_req) begin
                        state_d = ST_STEP;
                    end else if (run_req) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end
                end
                ST_STEP: state_d = ST_HALT;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Moore decode of the state plus the zero-latency memory write path
    always_comb begin
        cpu_reset  = 1'b0;
        cpu_clk_en = 1'b0;
        s_ready    = 1'b0;
        err        = 1'b0;
        case (state_q)
            ST_IDLE: cpu_reset = 1'b1;
            ST_LOAD: begin
                cpu_reset = 1'b1;
                s_ready   = 1'b1;
            end
            ST_RST:  cpu_reset = 1'b1;
            ST_RUN:  cpu_clk_en = 1'b1;
            ST_STEP: cpu_clk_en = 1'b1;
            ST_ERR: begin
                cpu_reset = 1'b1;
                err       = 1'b1;
            end
            default: cpu_reset = 1'b0;
        endcase
        imem_we    = hs;
        imem_addr  = hs ? ptr_q : '0;
        imem_wdata = hs ? prog.s_data : 8'h00;
    end

    // Write pointer and loaded flag: both restart whenever a load begins
    always_comb begin
        ptr_d    = ptr_q;
        loaded_d = loaded_q;
        if (load_req) begin
            ptr_d    = '0;
            loaded_d = 1'b0;
        end else begin
            if (hs) begin
                ptr_d = ptr_q + 1'b1;
            end
            if ((state_q == ST_RST) && rst_done) begin
                loaded_d = 1'b1;
            end
        end
    end

    // Pointer and loaded registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            loaded_q <= loaded_d;
        end
    end

`ifdef BOOT_CTRL_CYCLE_CNT_EN
    logic [15:0] cyc_q;
    logic [15:0] cyc_d;

    // Saturating count of enabled CPU cycles, cleared when a load begins
    always_comb begin
        cyc_d = cyc_q;
        if (load_req) begin
            cyc_d = 16'h0000;
        end else if (cpu_clk_en && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'h0001;
        end
    end

    // Cycle counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= 16'h0000;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycle_count = cyc_q;
`else
    assign cycle_count = 16'h0000;
`endif

endmodule

// File: tb/tb_boot_ctrl.sv
// Testbench for boot_ctrl. Two instances share one stimulus: dut_a uses the
// default geometry (256 bytes, 2 stretch cycles) and drives a small reference
// CPU model; dut_b uses an 8-byte memory and 3 stretch cycles for the
// overflow and reset-stretch corners.
module tb_boot_ctrl;
    import boot_ctrl_pkg::*;

`ifdef BOOT_CTRL_CYCLE_CNT_EN
    localparam logic [31:0] CC_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] CC_MASK = 32'h0000_0000;
`endif

    logic clk;
    logic reset;
    logic load_req, run_req, step_req, halt_req;
    logic s_valid, s_last;
    logic [7:0] s_data;

    logic        imem_we_a, cpu_reset_a, cpu_clk_en_a, loaded_a, err_a;
    logic [7:0]  imem_addr_a, imem_wdata_a;
    logic [15:0] cycle_count_a;
    state_t      st_a;

    logic        imem_we_b, cpu_reset_b, cpu_clk_en_b, loaded_b, err_b;
    logic [2:0]  imem_addr_b;
    logic [7:0]  imem_wdata_b;
    logic [15:0] cycle_count_b;
    state_t      st_b;

    int n_checks = 0;
    int n_errors = 0;

    boot_ctrl_if if_a ();
    boot_ctrl_if if_b ();

    assign if_a.s_valid = s_valid;
    assign if_a.s_data  = s_data;
    assign if_a.s_last  = s_last;
    assign if_b.s_valid = s_valid;
    assign if_b.s_data  = s_data;
    assign if_b.s_last  = s_last;

    boot_ctrl #(.MEM_DEPTH(256), .ADDR_W(8), .RST_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .load_req(load_req), .run_req(run_req),
        .step_req(step_req), .halt_req(halt_req), .prog(if_a),
        .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a),
        .cpu_reset(cpu_reset_a), .cpu_clk_en(cpu_clk_en_a), .loaded(loaded_a),
        .err(err_a), .cycle_count(cycle_count_a), .dbg_state(st_a)
    );

    boot_ctrl #(.MEM_DEPTH(8), .ADDR_W(3), .RST_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .load_req(load_req), .run_req(run_req),
        .step_req(step_req), .halt_req(halt_req), .prog(if_b),
        .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
        .cpu_reset(cpu_reset_b), .cpu_clk_en(cpu_clk_en_b), .loaded(loaded_b),
        .err(err_b), .cycle_count(cycle_count_b), .dbg_state(st_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference memory + CPU model behind dut_a ----------------
    logic [7:0]  mem_a [0:255];
    logic [15:0] regs  [0:7];
    logic [7:0]  pc;
    logic [15:0] instr;
    int          en_cnt;

    assign instr = {mem_a[pc], mem_a[pc + 8'd1]};

    always @(posedge clk) begin
        if (imem_we_a) mem_a[imem_addr_a] <= imem_wdata_a;
    end

    always @(posedge clk) begin
        if (cpu_reset_a) begin
            pc     <= 8'd0;
            en_cnt <= 0;
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0;
        end else if (cpu_clk_en_a) begin
            en_cnt <= en_cnt + 1;
            pc     <= pc + 8'd2;
            case (instr[OPC_MSB:OPC_LSB])
                OP_LI:  regs[instr[RD_MSB:RD_LSB]] <= {10'h000, instr[IMM_MSB:IMM_LSB]};
                OP_ADD: regs[instr[RD_MSB:RD_LSB]] <= regs[instr[RS_MSB:RS_LSB]] + regs[instr[RT_MSB:RT_LSB]];
                OP_SUB: regs[instr[RD_MSB:RD_LSB]] <= regs[instr[RS_MSB:RS_LSB]] - regs[instr[RT_MSB:RT_LSB]];
                default: ;
            endcase
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ld, input logic hl, input logic st, input logic rn);
        load_req = ld; halt_req = hl; step_req = st; run_req = rn;
        tick();
        load_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; run_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input int idx);
        s_valid = 1'b1; s_data = d; s_last = last;
        @(negedge clk);
        check($sformatf("we_a[%0d]", idx), imem_we_a, 1);
        check($sformatf("addr_a[%0d]", idx), imem_addr_a, 32'(idx));
        check($sformatf("wdata_a[%0d]", idx), imem_wdata_a, d);
        tick();
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    endtask

    logic [7:0] prog_bytes [8] = '{8'hF2, 8'h1E, 8'hF4, 8'h14, 8'h06, 8'h50, 8'h18, 8'h50};

    task automatic send_program();
        for (int i = 0; i < 8; i++) send_byte(prog_bytes[i], (i == 7), i);
    endtask

    task automatic check_regs(input string tag, input logic [15:0] r1, input logic [15:0] r2,
                              input logic [15:0] r3, input logic [15:0] r4);
        check({tag, "_r1"}, regs[1], r1);
        check({tag, "_r2"}, regs[2], r2);
        check({tag, "_r3"}, regs[3], r3);
        check({tag, "_r4"}, regs[4], r4);
    endtask

    // ---------------- run-control vector table ----------------
    typedef struct {
        logic   ld, hl, st, rn;
        state_t exp_state;
        logic   exp_rst, exp_en, exp_rdy, exp_loaded;
        int     exp_cc;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // Starting point for the table: dut_a in HALT after a fresh load
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_HALT, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, ST_RUN,  1'b0, 1'b1, 1'b0, 1'b1, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_RUN,  1'b0, 1'b1, 1'b0, 1'b1, 1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, ST_HALT, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, ST_STEP, 1'b0, 1'b1, 1'b0, 1'b1, 2};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_HALT, 1'b0, 1'b0, 1'b0, 1'b1, 3};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, ST_STEP, 1'b0, 1'b1, 1'b0, 1'b1, 3};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_HALT, 1'b0, 1'b0, 1'b0, 1'b1, 4};

        reset = 1'b1;
        load_req = 1'b0; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Reset values
        check("rst_state_a", 32'(st_a), 32'(ST_IDLE));
        check("rst_cpu_reset_a", cpu_reset_a, 1);
        check("rst_clk_en_a", cpu_clk_en_a, 0);
        check("rst_s_ready_a", if_a.s_ready, 0);
        check("rst_we_a", imem_we_a, 0);
        check("rst_addr_a", imem_addr_a, 0);
        check("rst_wdata_a", imem_wdata_a, 0);
        check("rst_loaded_a", loaded_a, 0);
        check("rst_err_a", err_a, 0);
        check("rst_cc_a", cycle_count_a, 0);

        // IDLE ignores run/step
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        check("idle_ignore_state", 32'(st_a), 32'(ST_IDLE));
        check("idle_ignore_en", cpu_clk_en_a, 0);

        // First load, with reset-stretch timing on both instances
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("load_s_ready_a", if_a.s_ready, 1);
        check("load_cpu_reset_a", cpu_reset_a, 1);
        send_program();
        check("str_n0_rst_a", cpu_reset_a, 1);
        check("str_n0_rst_b", cpu_reset_b, 1);
        check("str_n0_state_a", 32'(st_a), 32'(ST_RST));
        tick();
        check("str_n1_rst_a", cpu_reset_a, 1);
        check("str_n1_loaded_a", loaded_a, 0);
        tick();
        check("str_n2_rst_a", cpu_reset_a, 0);
        check("str_n2_state_a", 32'(st_a), 32'(ST_HALT));
        check("str_n2_loaded_a", loaded_a, 1);
        check("str_n2_rst_b", cpu_reset_b, 1);
        tick();
        check("str_n3_rst_b", cpu_reset_b, 0);
        check("str_n3_loaded_b", loaded_b, 1);

        // Run-control table
        for (int i = 0; i < 8; i++) begin
            pulse(vecs[i].ld, vecs[i].hl, vecs[i].st, vecs[i].rn);
            check($sformatf("vec%0d_state", i), 32'(st_a), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d_rst", i), cpu_reset_a, vecs[i].exp_rst);
            check($sformatf("vec%0d_en", i), cpu_clk_en_a, vecs[i].exp_en);
            check($sformatf("vec%0d_rdy", i), if_a.s_ready, vecs[i].exp_rdy);
            check($sformatf("vec%0d_loaded", i), loaded_a, vecs[i].exp_loaded);
            check($sformatf("vec%0d_err", i), err_a, 0);
            check($sformatf("vec%0d_cc", i), cycle_count_a, 32'(vecs[i].exp_cc) & CC_MASK);
        end
        check("table_en_cnt", en_cnt, 4);
        check_regs("table", 16'd30, 16'd20, 16'd50, 16'd10);

        // load_req beats run_req in HALT; then single-step the program
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        check("ldrun_state", 32'(st_a), 32'(ST_LOAD));
        check("ldrun_loaded", loaded_a, 0);
        check("ldrun_cc", cycle_count_a, 0);
        send_program();
        repeat (3) tick();
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("step1_en", cpu_clk_en_a, 1);
        tick();
        check("step1_back_halt", 32'(st_a), 32'(ST_HALT));
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("step2_en_cnt", en_cnt, 2);
        check("step2_cc", cycle_count_a, 32'd2 & CC_MASK);
        check_regs("step2", 16'd30, 16'd20, 16'd0, 16'd0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("step3_r3", regs[3], 16'd50);

        // Reset while loaded clears loaded
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_halt_state", 32'(st_a), 32'(ST_IDLE));
        check("rst_halt_loaded", loaded_a, 0);
        check("rst_halt_cpu_reset", cpu_reset_a, 1);

        // Overflow on the 8-byte instance
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0, i);
        check("ovf_err_b", err_b, 1);
        check("ovf_rdy_b", if_b.s_ready, 0);
        check("ovf_rst_b", cpu_reset_b, 1);
        check("ovf_state_b", 32'(st_b), 32'(ST_ERR));
        check("ovf_err_a", err_a, 0);
        s_valid = 1'b1; s_data = 8'h55;
        @(negedge clk);
        check("ovf9_we_b", imem_we_b, 0);
        check("ovf9_addr_a", imem_addr_a, 8);
        tick();
        s_valid = 1'b0; s_data = 8'h00;
        check("ovf_hold_err_b", err_b, 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("ovf_clr_err_b", err_b, 0);
        check("ovf_clr_rdy_b", if_b.s_ready, 1);
        send_byte(8'hAA, 1'b0, 0);

        // Reset mid-load
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(prog_bytes[i], 1'b0, i);
        reset = 1'b1; s_valid = 1'b1; s_data = 8'h77;
        tick();
        reset = 1'b0;
        check("midrst_state", 32'(st_a), 32'(ST_IDLE));
        check("midrst_we", imem_we_a, 0);
        check("midrst_addr", imem_addr_a, 0);
        check("midrst_loaded", loaded_a, 0);
        s_valid = 1'b0; s_data = 8'h00;

        // Fresh full load and free run of 4 enabled cycles
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        send_program();
        repeat (3) tick();
        check("fresh_loaded", loaded_a, 1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("fresh_en_off", cpu_clk_en_a, 0);
        check("fresh_en_cnt", en_cnt, 4);
        check("fresh_cc", cycle_count_a, 32'd4 & CC_MASK);
        check_regs("fresh", 16'd30, 16'd20, 16'd50, 16'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/boot_ctrl.md
# boot_ctrl

Boot and run controller for the single-cycle CPU. It accepts a program as a byte stream over a valid/ready handshake and writes it into the byte-wide instruction memory. While loading, it holds the CPU in reset, then stretches reset and releases the core into a halted state. From there it sequences the CPU clock enable: free run, single step or halt. It sits between the test or host interface and `top_cpu`, driving the core's `reset` and a clock-enable input.

## Interface
- `MEM_DEPTH`, 256: instruction memory size in bytes; power of two, minimum 4.
- `ADDR_W`, 8: instruction memory address width; `2**ADDR_W == MEM_DEPTH`.
- `RST_CYCLES`, 2: number of cycles `cpu_reset` is held after a load completes; minimum 1.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `load_req` in 1: single-cycle pulse; starts or restarts a program load.
- `run_req` / `step_req` / `halt_req` in 1 each: single-cycle run-control pulses.
- `s_valid` in 1: program byte valid.
- `s_data` in 8: program byte. The upper instruction byte goes at the even address.
- `s_last` in 1: marks the final program byte.
- `s_ready` out 1: controller accepts a byte.
- `imem_we` out 1: instruction memory write strobe.
- `imem_addr` out ADDR_W: instruction memory write address.
- `imem_wdata` out 8: instruction memory write data.
- `cpu_reset` out 1: drives the CPU's `reset`.
- `cpu_clk_en` out 1: CPU clock enable; the CPU state advances only on cycles where this is 1.
- `loaded` out 1: a complete program is in memory.
- `err` out 1: overflow occurred.
- `cycle_count` out 16: number of enabled CPU cycles since the last load.

## Operation
- **States:** IDLE, LOAD, RST, HALT, RUN, STEP, ERR.
- **Moore decode of the state register:**
  - `cpu_reset` = 1 in IDLE, LOAD, RST and ERR.
  - `cpu_clk_en` = 1 in RUN and STEP.
  - `s_ready` = 1 only in LOAD.
  - `err` = 1 only in ERR.
- **IDLE:** `load_req` moves to LOAD; all other requests are ignored.
- **LOAD:** entry clears the write pointer, `loaded` and `cycle_count`.
  - On each handshake (`s_valid & s_ready`): `imem_we` = 1, `imem_addr` = pointer, `imem_wdata` = `s_data`, and the pointer increments.
  - Handshake with `s_last` moves to RST.
  - Handshake at pointer `MEM_DEPTH-1` without `s_last` moves to ERR.
- **RST:** a counter runs `RST_CYCLES` cycles, then the state moves to HALT and `loaded` is set to 1.
- **HALT:** `run_req` moves to RUN; `step_req` moves to STEP.
- **RUN:** `halt_req` moves to HALT.
- **STEP:** always returns to HALT after exactly one cycle.
- **ERR:** held until `load_req`.
- **`load_req`:** taken from every state, including LOAD, where it restarts the pointer at 0.
- **Request priority when pulses coincide:** `load_req` > `halt_req` > `step_req` > `run_req`. Requests that are not legal in the current state are dropped, not queued.
- **`cycle_count`:** increments on every cycle with `cpu_clk_en` = 1 and saturates at 16'hFFFF.

## Timing
- **Reset values:** state IDLE, `cpu_reset` = 1, `cpu_clk_en` = 0, `s_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0 when idle, `loaded` = 0, `err` = 0, `cycle_count` = 0.
- **Write path:** `imem_we`, `imem_addr` and `imem_wdata` are combinational from the handshake, giving zero-latency writes. The memory captures on the same edge.
- **Request latency:** a request sampled at edge N takes effect on outputs from edge N+1.
  - A step yields exactly one `cpu_clk_en` cycle, which executes one instruction.
- **Load completion:** after the `s_last` handshake at edge N, `cpu_reset` stays 1 through edge N+`RST_CYCLES`. HALT, with `cpu_reset` = 0, begins after that edge.
- **Reset during any state:** state returns to IDLE on the next edge. A partial load is discarded and `loaded` is cleared.
- **Handshake stalls:** `s_valid` low in LOAD stalls indefinitely; there is no timeout.

## Configuration
- **`BOOT_CTRL_CYCLE_CNT_EN`:**
  - Defined: the saturating 16-bit `cycle_count` register exists as described.
  - Undefined: the register is not instantiated and `cycle_count` is tied to 0.

## Structure
- **Package `boot_ctrl_pkg`:**
  - State enum.
  - Instruction field constants: opcode[15:12], rd[11:9], rs[8:6], rt[5:3], imm[5:0].
  - Opcodes: ADD = 4'b0000, SUB = 4'b0001, LI = 4'b1111.
- **Sub-module `rst_stretch`:** the RST-state down-counter, loaded with `RST_CYCLES` and raising done on reaching zero.

## Test plan
- **Load and run:** load 8 bytes F2 1E F4 14 06 50 18 50 with `s_last` on byte 8, then `run_req` → `loaded` = 1. After 4 enabled cycles R1 = 30, R2 = 20, R3 = 50, R4 = 10.
- **Single step:** same load, then `step_req` ×2 → `cycle_count` = 2, R1 = 30, R2 = 20, R3 = 0. A third step → R3 = 50.
- **Overflow:** with `MEM_DEPTH` = 8, send 9 bytes with no `s_last` → `err` = 1 after the 8th handshake, `s_ready` = 0, `cpu_reset` = 1. `load_req` then clears `err`.
- **Simultaneous requests:** `halt_req` and `step_req` in the same cycle in RUN → HALT, with no extra enable cycle. `load_req` with `run_req` in HALT → LOAD.
- **Reset mid-load:** `reset` after 3 bytes → IDLE, `imem_addr` = 0, `loaded` = 0. A fresh full load then runs correctly.
- **Reset stretch:** with `RST_CYCLES` = 3, check that `cpu_reset` falls exactly 3 edges after the `s_last` handshake.
